// File: rtl/wb_arbiter_if.sv
// Writeback bus between the ALU/load result sources and the arbiter, plus the bank-side outputs.
// The slave modport is the arbiter's view; the master modport is the result producers' view.
interface wb_arbiter_if #(
  parameter int N     = 32,
  parameter int DEPTH = 4
);
  logic                     alu_valid;
  logic [4:0]               alu_dest;
  logic [N-1:0]             alu_data;
  logic                     mem_valid;
  logic [4:0]               mem_dest;
  logic [N-1:0]             mem_data;
  logic                     mem_ready;
  logic                     write;
  logic [4:0]               dest;
  logic [N-1:0]             w_data;
  logic [$clog2(DEPTH):0]   fifo_count;

  modport slave (
    input  alu_valid, alu_dest, alu_data, mem_valid, mem_dest, mem_data,
    output mem_ready, write, dest, w_data, fifo_count
  );

  modport master (
    output alu_valid, alu_dest, alu_data, mem_valid, mem_dest, mem_data,
    input  mem_ready, write, dest, w_data, fifo_count
  );
endinterface

// File: rtl/wb_arbiter.sv
// Merges ALU results (priority) and queued load returns into one register-bank write per cycle.
// Latency: 1 cycle from sampling edge to registered write/dest/w_data; queued loads wait for an idle ALU cycle.
// Backpressure: ALU never stalls; mem_ready drops only while the load FIFO is full (registered count).
module wb_arbiter #(
  parameter int N     = 32,
  parameter int DEPTH = 4
) (
  input logic         clk,
  input logic         rst,
  wb_arbiter_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  typedef struct packed {
    logic [4:0]   dest;
    logic [N-1:0] data;
  } ent_t;

  ent_t          fifo_q [DEPTH];
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          write_q, write_d;
  logic [4:0]    dest_q, dest_d;
  logic [N-1:0]  data_q, data_d;

  logic alu_live, mem_acc, mem_live, fifo_empty, pop, push, bypass;

  assign bus.mem_ready  = (count_q < DEPTH_C);
  assign bus.write      = write_q;
  assign bus.dest       = dest_q;
  assign bus.w_data     = data_q;
  assign bus.fifo_count = count_q;

  always_comb begin
    alu_live   = bus.alu_valid && (bus.alu_dest[3:0] != 4'd0);
    mem_acc    = bus.mem_valid && bus.mem_ready;
    mem_live   = mem_acc && (bus.mem_dest[3:0] != 4'd0);
    fifo_empty = (count_q == '0);
    pop        = !alu_live && !fifo_empty;
    bypass     = !alu_live && fifo_empty && mem_live;
    push       = mem_live && !bypass;

    rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    count_d  = count_q + {{(CW-1){1'b0}}, push} - {{(CW-1){1'b0}}, pop};

    write_d = 1'b0;
    dest_d  = dest_q;
    data_d  = data_q;
    if (alu_live) begin
      write_d = 1'b1;
      dest_d  = bus.alu_dest;
      data_d  = bus.alu_data;
    end else if (pop) begin
      write_d = 1'b1;
      dest_d  = fifo_q[rd_ptr_q].dest;
      data_d  = fifo_q[rd_ptr_q].data;
    end else if (bypass) begin
      write_d = 1'b1;
      dest_d  = bus.mem_dest;
      data_d  = bus.mem_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      write_q  <= 1'b0;
      dest_q   <= '0;
      data_q   <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      write_q  <= write_d;
      dest_q   <= dest_d;
      data_q   <= data_d;
    end
  end

  // Storage needs no reset: the count and pointers define which slots are valid.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_q[wr_ptr_q] <= '{dest: bus.mem_dest, data: bus.mem_data};
    end
  end
endmodule

// File: tb/tb_wb_arbiter.sv
// Directed bench for wb_arbiter: a queue-based reference model checked every cycle,
// plus literal expectations for the reset, pass-through, bypass, fill, R0 and wrap scenarios.
module tb_wb_arbiter;
  localparam int N     = 32;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  wb_arbiter_if #(.N(N), .DEPTH(DEPTH)) bus ();
  wb_arbiter #(.N(N), .DEPTH(DEPTH)) dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct {
    logic [4:0]  d;
    logic [31:0] v;
  } ent_t;

  ent_t        mq[$];
  logic [4:0]  issued[$];
  logic        exp_write;
  logic [4:0]  exp_dest;
  logic [31:0] exp_data;
  int          exp_count;
  int          max_count;
  logic        chk_en = 1'b0;
  int          n_cmp  = 0;
  int          n_fail = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    exp_write = 1'b0;
    exp_dest  = '0;
    exp_data  = '0;
    exp_count = 0;
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("write", 64'(bus.write), 64'(exp_write));
      chk("dest", 64'(bus.dest), 64'(exp_dest));
      chk("w_data", 64'(bus.w_data), 64'(exp_data));
      chk("fifo_count", 64'(bus.fifo_count), 64'(exp_count));
      chk("mem_ready", 64'(bus.mem_ready), 64'(exp_count < DEPTH));
    end
  end

  // One cycle: drive inputs, advance past the edge, then update the model.
  task automatic step(input logic av, input logic [4:0] ad, input logic [31:0] adat,
                      input logic mv, input logic [4:0] md, input logic [31:0] mdat,
                      output logic acc);
    logic alu_live, mem_live, byp;
    ent_t e;
    bus.alu_valid = av;  bus.alu_dest = ad;  bus.alu_data = adat;
    bus.mem_valid = mv;  bus.mem_dest = md;  bus.mem_data = mdat;
    acc      = mv && (mq.size() < DEPTH);
    alu_live = av && (ad[3:0] != 4'd0);
    mem_live = acc && (md[3:0] != 4'd0);
    byp      = 1'b0;
    @(posedge clk);
    #1;
    exp_write = 1'b0;
    if (alu_live) begin
      exp_write = 1'b1; exp_dest = ad; exp_data = adat;
    end else if (mq.size() > 0) begin
      e = mq.pop_front();
      exp_write = 1'b1; exp_dest = e.d; exp_data = e.v;
      issued.push_back(e.d);
    end else if (mem_live) begin
      byp = 1'b1;
      exp_write = 1'b1; exp_dest = md; exp_data = mdat;
      issued.push_back(md);
    end
    if (mem_live && !byp) mq.push_back('{d: md, v: mdat});
    exp_count = mq.size();
    if (exp_count > max_count) max_count = exp_count;
  endtask

  task automatic idle(input int n);
    logic acc;
    for (int i = 0; i < n; i++) step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, acc);
  endtask

  initial begin
    logic       acc;
    logic [4:0] mdl[6];
    int         sent;
    int         guard;

    mdl[0] = 5'd1; mdl[1] = 5'd2; mdl[2] = 5'd3; mdl[3] = 5'd4; mdl[4] = 5'd6; mdl[5] = 5'd7;
    max_count = 0;
    rst = 1'b1;
    bus.alu_valid = 1'b0; bus.alu_dest = '0; bus.alu_data = '0;
    bus.mem_valid = 1'b0; bus.mem_dest = '0; bus.mem_data = '0;
    #12;
    chk("rst_write", 64'(bus.write), 64'd0);
    chk("rst_count", 64'(bus.fifo_count), 64'd0);
    chk("rst_ready", 64'(bus.mem_ready), 64'd1);
    chk("rst_dest", 64'(bus.dest), 64'd0);
    model_reset();
    rst = 1'b0;
    chk_en = 1'b1;

    // ALU pass-through
    step(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'd0, acc);
    chk("alu_write", 64'(bus.write), 64'd1);
    chk("alu_dest", 64'(bus.dest), 64'd5);
    chk("alu_data", 64'(bus.w_data), 64'hDEADBEEF);
    idle(1);
    chk("alu_write_drop", 64'(bus.write), 64'd0);
    chk("alu_dest_hold", 64'(bus.dest), 64'd5);

    // Bypass
    issued.delete();
    step(1'b0, 5'd0, 32'd0, 1'b1, 5'd3, 32'h1234, acc);
    chk("byp_write", 64'(bus.write), 64'd1);
    chk("byp_dest", 64'(bus.dest), 64'd3);
    chk("byp_data", 64'(bus.w_data), 64'h1234);
    chk("byp_count", 64'(bus.fifo_count), 64'd0);
    idle(1);

    // Contention and fill
    issued.delete();
    sent = 0;
    for (int c = 0; c < 6; c++) begin
      step(1'b1, 5'd9, 32'hA000 + c, sent < 6, mdl[sent % 6], 32'hB000 + sent, acc);
      if (acc) sent++;
      if (c == 3) begin
        chk("fill_count", 64'(bus.fifo_count), 64'd4);
        chk("fill_ready", 64'(bus.mem_ready), 64'd0);
      end
    end
    chk("fill_sent", 64'(sent), 64'd4);
    step(1'b0, 5'd0, 32'd0, 1'b1, mdl[sent % 6], 32'hB000 + sent, acc);
    chk("dest6_held", 64'(acc), 64'd0);
    chk("first_pop_dest", 64'(bus.dest), 64'd1);
    guard = 0;
    while ((sent < 6 || mq.size() > 0) && guard < 40) begin
      step(1'b0, 5'd0, 32'd0, sent < 6, mdl[sent % 6], 32'hB000 + sent, acc);
      if (acc) sent++;
      guard++;
    end
    chk("fill_timeout", 64'(guard < 40), 64'd1);
    chk("fill_issued_n", 64'(issued.size()), 64'd6);
    for (int i = 0; i < 6 && i < issued.size(); i++) chk("fill_order", 64'(issued[i]), 64'(mdl[i]));
    idle(1);

    // R0 suppression
    step(1'b1, 5'd0, 32'h1111, 1'b1, 5'd16, 32'h2222, acc);
    chk("r0_acc", 64'(acc), 64'd1);
    chk("r0_write", 64'(bus.write), 64'd0);
    chk("r0_count", 64'(bus.fifo_count), 64'd0);
    idle(1);

    // Wrap-around: 10 loads through the 4-entry ring
    issued.delete();
    max_count = 0;
    sent = 0;
    guard = 0;
    while ((sent < 10 || mq.size() > 0) && guard < 80) begin
      step(guard % 2 == 0 && sent < 10, 5'd15, 32'hC000 + guard,
           sent < 10, 5'(sent + 1), 32'hD000 + sent, acc);
      if (acc) sent++;
      guard++;
    end
    chk("wrap_timeout", 64'(guard < 80), 64'd1);
    chk("wrap_max_count", 64'(max_count), 64'd4);
    chk("wrap_issued_n", 64'(issued.size()), 64'd10);
    for (int i = 0; i < 10 && i < issued.size(); i++) chk("wrap_order", 64'(issued[i]), 64'(i + 1));
    idle(1);

    // Reset mid-operation with two queued entries
    step(1'b1, 5'd12, 32'hE0, 1'b1, 5'd2, 32'hF2, acc);
    step(1'b1, 5'd12, 32'hE1, 1'b1, 5'd3, 32'hF3, acc);
    chk("pre_rst_count", 64'(bus.fifo_count), 64'd2);
    chk("pre_rst_write", 64'(bus.write), 64'd1);
    bus.alu_valid = 1'b0;
    bus.mem_valid = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    chk("mid_rst_write", 64'(bus.write), 64'd0);
    chk("mid_rst_count", 64'(bus.fifo_count), 64'd0);
    chk("mid_rst_ready", 64'(bus.mem_ready), 64'd1);
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
    idle(3);
    chk("post_rst_write", 64'(bus.write), 64'd0);

    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/wb_arbiter.md
# wb_arbiter

Writeback arbiter that sits directly upstream of the 16-entry register bank and drives its `write`, `dest` and `w_data` inputs. It merges two result streams into one register write per cycle:
- single-cycle ALU results, which always win;
- variable-latency memory load returns, which are buffered in a small FIFO and drained in idle ALU cycles.

Writes targeting register 0 are discarded here, so the bank never sees them.

## Interface
Parameters:
- N, 32, data width (matches register bank width)
- DEPTH, 4, load-return FIFO entries (power of two, ≥2)

Ports:
- clk  input  1  clock; all state updates on posedge
- rst  input  1  reset, asynchronous, active-high
- alu_valid  input  1  ALU result present this cycle
- alu_dest  input  5  ALU destination register
- alu_data  input  N  ALU result
- mem_valid  input  1  load return present this cycle
- mem_dest  input  5  load destination register
- mem_data  input  N  load data
- mem_ready  output  1  FIFO can accept a load return this cycle
- write  output  1  register bank write enable (registered)
- dest  output  5  register bank destination (registered)
- w_data  output  N  register bank write data (registered)
- fifo_count  output  log2(DEPTH)+1  occupied FIFO entries (registered)

## Operation
Register 0 filter:
- A result is "live" when valid=1 and dest[3:0]!=0.
- dest[4] is passed through unchanged; the bank ignores it.
- Non-live results are discarded silently.
- A discarded mem result still completes its handshake.

Arbitration, evaluated each posedge:
- Live ALU result: highest priority; it is issued.
- Otherwise, FIFO not empty: the head entry is popped and issued.
- Otherwise, live mem accepted this cycle: bypasses the FIFO and is issued directly.
- Otherwise: write=0. dest and w_data hold their last values.

Load handshake and FIFO:
- A mem result is accepted when mem_valid && mem_ready.
- An accepted mem result is pushed into the FIFO unless it is non-live or bypassed.
- mem_ready = (fifo_count < DEPTH). It is combinational from registered count only, never from same-cycle inputs.
- Push and pop in the same cycle: count unchanged, ordering preserved.
- The FIFO is a circular buffer. Read and write pointers wrap modulo DEPTH. Count is held separately to distinguish full from empty.
- Load returns issue in acceptance order.
- ALU results are never stalled; there is no alu_ready.

Ordering:
- Upstream guarantees that no ALU result and no pending load target the same register simultaneously. No cross-stream reordering check is done.

## Timing
- Latency: a result sampled at posedge t appears on write/dest/w_data after posedge t, and is held through cycle t+1. The bank commits it at posedge t+1.
- Throughput: one bank write per cycle maximum.
- Load latency:
  - bypass: 1 cycle;
  - queued: 1 cycle after it reaches the FIFO head with ALU idle.
- Full FIFO, ALU busy: mem_ready=0. A simultaneous mem_valid is not accepted and must be held by the source.
- Full FIFO, ALU idle: a pop occurs at posedge, so mem_ready returns to 1 in the next cycle.
- Reset values: write=0, dest=0, w_data=0, fifo_count=0, mem_ready=1. Pointers are 0.
- Reset mid-operation: all queued entries are lost. write drops to 0 immediately (asynchronous), not at the next edge.
- After rst deasserts, the first posedge behaves as a normal cycle.

## Test plan
- Reset: assert rst with FIFO holding 2 entries. Required: write=0, fifo_count=0, mem_ready=1 immediately; no write after release.
- ALU pass-through: alu_valid=1, alu_dest=5, alu_data=0xDEADBEEF at posedge t. Required: write=1, dest=5, w_data=0xDEADBEEF in cycle t+1, then write=0.
- Bypass: ALU idle, FIFO empty, mem_valid=1, mem_dest=3, mem_data=0x1234. Required: write=1, dest=3, w_data=0x1234 next cycle; fifo_count stays 0.
- Contention and fill: alu_valid=1 for 6 cycles, mem_valid=1 with dests 1,2,3,4,6,7. Required:
  - fifo_count reaches 4 and mem_ready drops;
  - dest 6 is not accepted until a pop;
  - after ALU goes idle, writes occur to 1,2,3,4,6,7 in order, one per cycle.
- R0 suppression: alu_dest=0 with alu_valid=1, and a simultaneous mem_dest=16 (dest[3:0]=0). Required: write stays 0, fifo_count stays 0, mem handshake completes.
- Wrap-around: push/pop 10 entries, dests 1..10, with ALU alternating busy/idle. Required: in-order issue and count never >4. Pointer wrap occurs at least twice.
